// File: rtl/digit_scan_mux.sv
// rtl/digit_scan_mux.sv - N-digit 7-segment scanner with prescaler, blanking and frame pulse
// Optional macro DIG_SCAN_GAP_EN inserts a one-cycle dark gap at every digit change.
module digit_scan_mux #(
    parameter int NUM_DIG  = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [4*NUM_DIG-1:0]   data,
    input  logic [NUM_DIG-1:0]     dp,
    input  logic [NUM_DIG-1:0]     blank,
    output logic [NUM_DIG-1:0]     dig,
    output logic [6:0]             seg,
    output logic                   seg_dp,
    output logic                   frame_tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (NUM_DIG > 2) ? $clog2(NUM_DIG) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DIG - 1);
    localparam logic [NUM_DIG-1:0] DIG_ONE  = NUM_DIG'(1);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             cnt_last;
    logic             idx_last;
    logic             lit;
    logic             show;
    logic [3:0]       nib;

    // Segment patterns, bit 6 = g down to bit 0 = a.
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0:    decode = 7'b0111111;
            4'h1:    decode = 7'b0000110;
            4'h2:    decode = 7'b1011011;
            4'h3:    decode = 7'b1001111;
            4'h4:    decode = 7'b1100110;
            4'h5:    decode = 7'b1101101;
            4'h6:    decode = 7'b1111101;
            4'h7:    decode = 7'b0000111;
            4'h8:    decode = 7'b1111111;
            4'h9:    decode = 7'b1101111;
            4'hA:    decode = 7'b1110111;
            4'hB:    decode = 7'b1111100;
            4'hC:    decode = 7'b0111001;
            4'hD:    decode = 7'b1011110;
            4'hE:    decode = 7'b1111001;
            4'hF:    decode = 7'b1110001;
            default: decode = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        cnt_last = (cnt == CNT_LAST);
        idx_last = (idx == IDX_LAST);
        nib      = data[{idx, 2'b00} +: 4];
`ifdef DIG_SCAN_GAP_EN
        // Last cycle of each slot stays dark so the old digit never bleeds into the next.
        lit      = en && !cnt_last;
`else
        lit      = en;
`endif
        show     = lit && !blank[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            dig        <= '0;
            seg        <= '0;
            seg_dp     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            if (en) begin
                if (cnt_last) begin
                    cnt <= '0;
                    idx <= idx_last ? '0 : idx + IDX_W'(1);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            dig        <= lit ? (DIG_ONE << idx) : '0;
            seg        <= show ? decode(nib) : '0;
            seg_dp     <= show && dp[idx];
            frame_tick <= en && idx_last && cnt_last;
        end
    end

endmodule

// File: doc/digit_scan_mux.md
Name: digit_scan_mux

Overview:
- Parametrised time-multiplexed display scanner for common-anode/cathode N-digit 7-segment displays. Next generation of the team's fixed 2-to-4 digit-select decoder.
- Contains the clock prescaler, a wrapping digit index counter, one-hot digit select, per-digit hex-to-7-segment decode, blanking and a frame pulse.
- Sits between the register file holding display nibbles and the board pins.

Parameters:
NUM_DIG, 4, number of digits scanned; legal range 2..16.
PRESCALE, 50000, clk cycles per digit slot; legal range >= 2.

Ports:
clk  input  1  system clock; the block's only clock
rst  input  1  reset; synchronous, active-high
en  input  1  scan enable; 0 = counters hold and display dark
data  input  4*NUM_DIG  hex nibbles; digit k = data[4k+3:4k]
dp  input  NUM_DIG  decimal point request per digit
blank  input  NUM_DIG  1 = digit k shown dark (segments off, select still scanned)
dig  output  NUM_DIG  one-hot digit select, active-high
seg  output  7  segments, active-high; seg[0]=a ... seg[6]=g
seg_dp  output  1  decimal point, active-high
frame_tick  output  1  one-cycle pulse per completed scan frame

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Internal state:
  - cnt: prescaler, width clog2(PRESCALE).
  - idx: digit index, width clog2(NUM_DIG), minimum 1.
- Reset, on the clk edge with rst=1: cnt=0, idx=0, dig=0, seg=0, seg_dp=0, frame_tick=0.
  - rst overrides en and everything else.
  - rst asserted mid-slot or mid-frame aborts the scan. The next scan starts at digit 0 with a full slot.
- Counting, en=1:
  - cnt increments each cycle.
  - When cnt==PRESCALE-1: cnt<=0, and idx<=idx+1, wrapping NUM_DIG-1 -> 0. No out-of-range index is ever held.
- en=0: cnt and idx hold; dig, seg, seg_dp and frame_tick are registered to 0 on the next edge. Re-asserting en resumes from the held cnt/idx.
- Outputs are all registered, 1-cycle latency. Output in cycle n+1 reflects cnt, idx and inputs sampled in cycle n:
  - dig <= en ? (1<<idx) : 0
  - seg <= (en && !blank[idx]) ? decode(nibble idx) : 0
  - seg_dp <= en && !blank[idx] && dp[idx]
  - frame_tick <= en && idx==NUM_DIG-1 && cnt==PRESCALE-1
- Decode table, g..a bit order:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- data, dp and blank are sampled live every cycle, not latched per slot. A mid-slot change appears 1 cycle later.
- dig is always one-hot or all-zero. It is never multi-hot, including across reset and en edges.
- Synthesizable. No latches; the case/decode default is fully specified.

Optional Feature:
- Macro: DIG_SCAN_GAP_EN.
- Defined: anti-ghosting gap.
  - In any cycle where cnt==PRESCALE-1, dig, seg and seg_dp are registered to 0.
  - Each digit is lit PRESCALE-1 cycles per slot, then dark for 1 cycle across every digit change, including the wrap.
  - frame_tick is unaffected.
- Undefined: no gap. Each digit is lit all PRESCALE cycles of its slot.

Test Plan:
- Scan order (NUM_DIG=4, PRESCALE=4, gap off): rst=1 then 0 with en=1 from cycle 0.
  - dig=0001 in cycles 1-4, 0010 in 5-8, 0100 in 9-12, 1000 in 13-16, 0001 again from 17.
  - frame_tick=1 only in cycle 16.
- Decode: data=16'h3A5F, dp=4'b0100, blank=0.
  - Digit 0 slot: seg=1110001.
  - Digit 1: seg=1101101.
  - Digit 2: seg=1110111, seg_dp=1.
  - Digit 3: seg=1001111.
- Blank and enable:
  - blank=4'b0010 -> during digit 1 slot, dig=0010 with seg=0 and seg_dp=0.
  - Drop en for 10 cycles mid-slot -> all outputs 0 one cycle later, cnt/idx frozen. The slot completes its remaining cycles after en returns.
- Reset mid-operation: assert rst during digit 2 slot.
  - Next cycle: all outputs 0.
  - After release: digit 0 slot of full length, no spurious frame_tick.
- Gap feature (DIG_SCAN_GAP_EN defined, PRESCALE=4): dig=0001 in cycles 1-3, 0000 in cycle 4, 0010 in cycles 5-7, 0000 in cycle 8. Never two bits set.
- Parameter sweep: NUM_DIG=2,3,8 with PRESCALE=2.
  - idx wraps at NUM_DIG-1, dig one-hot across all NUM_DIG positions.
  - frame_tick period = NUM_DIG*PRESCALE cycles.
